ddr4_avmm_rr_arbiter: RTL

//  Round-robin arbiter sharing one DDR4 Avalon-MM bank (DDR4a or DDR4b) between NUM_REQ AFU-side

---
 rtl/ddr4_avmm_rr_arbiter_if.sv | 50 +++++
 rtl/ddr4_avmm_rr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_avmm_rr_arbiter_if.sv
// rtl/ddr4_avmm_rr_arbiter_if.sv - Avalon-MM bundle between the AFU masters, the arbiter and one DDR4 bank
//
// Purpose: groups the packed per-master request/response signals and the single DDR4 bank port.
// Ports (signals):
//   m_read/m_write/m_address/m_writedata/m_byteenable/m_burstcount  AFU masters -> arbiter (packed, master i at slice i)
//   m_waitrequest/m_readdata/m_readdatavalid                         arbiter -> AFU masters
//   DDR4_read/DDR4_write/DDR4_address/DDR4_writedata/DDR4_byteenable/DDR4_burstcount  arbiter -> bank
//   DDR4_waitrequest/DDR4_readdata/DDR4_readdatavalid                bank -> arbiter
// Modports: slave = arbiter view, master = AFU/bank environment view.
interface ddr4_avmm_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 512,
    parameter int BE_W    = 64,
    parameter int BURST_W = 7
);
    logic [NUM_REQ-1:0]         m_read;
    logic [NUM_REQ-1:0]         m_write;
    logic [NUM_REQ*ADDR_W-1:0]  m_address;
    logic [NUM_REQ*DATA_W-1:0]  m_writedata;
    logic [NUM_REQ*BE_W-1:0]    m_byteenable;
    logic [NUM_REQ*BURST_W-1:0] m_burstcount;
    logic [NUM_REQ-1:0]         m_waitrequest;
    logic [DATA_W-1:0]          m_readdata;
    logic [NUM_REQ-1:0]         m_readdatavalid;

    logic                       DDR4_waitrequest;
    logic [DATA_W-1:0]          DDR4_readdata;
    logic                       DDR4_readdatavalid;
    logic                       DDR4_read;
    logic                       DDR4_write;
    logic [ADDR_W-1:0]          DDR4_address;
    logic [DATA_W-1:0]          DDR4_writedata;
    logic [BE_W-1:0]            DDR4_byteenable;
    logic [BURST_W-1:0]         DDR4_burstcount;

    modport slave (
        input  m_read, m_write, m_address, m_writedata, m_byteenable, m_burstcount,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  DDR4_waitrequest, DDR4_readdata, DDR4_readdatavalid,
        output DDR4_read, DDR4_write, DDR4_address, DDR4_writedata, DDR4_byteenable, DDR4_burstcount
    );

    modport master (
        output m_read, m_write, m_address, m_writedata, m_byteenable, m_burstcount,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output DDR4_waitrequest, DDR4_readdata, DDR4_readdatavalid,
        input  DDR4_read, DDR4_write, DDR4_address, DDR4_writedata, DDR4_byteenable, DDR4_burstcount
    );
endinterface

// File: rtl/ddr4_avmm_rr_arbiter.sv
// rtl/ddr4_avmm_rr_arbiter.sv - burst-aware round-robin arbiter sharing one DDR4 Avalon-MM bank
//
// Purpose: NUM_REQ AFU masters share one DDR4 bank. Commands are granted round-robin, a write burst
//   keeps the grant until its last beat, and read returns are steered back in order through a tag FIFO.
// Ports:
//   DDR4_USERCLK  in   sole clock
//   SoftReset_n   in   synchronous reset, active low
//   bus           slave modport of ddr4_avmm_rr_arbiter_if (masters side and bank side)
//   rsp_err       out  sticky: read data returned while no read burst was outstanding
module ddr4_avmm_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 26,
    parameter int DATA_W         = 512,
    parameter int BE_W           = 64,
    parameter int BURST_W        = 7,
    parameter int RSP_FIFO_DEPTH = 16
) (
    input  logic                      DDR4_USERCLK,
    input  logic                      SoftReset_n,
    ddr4_avmm_rr_arbiter_if.slave     bus,
    output logic                      rsp_err
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [GW-1:0]        r_grant, w_grant_nxt;
    logic [GW-1:0]        r_last_grant, w_last_nxt;
    logic [BURST_W-1:0]   r_beat_cnt, w_beat_nxt;
    logic [BURST_W-1:0]   r_wr_len, w_len_nxt;
    logic [BURST_W-1:0]   w_len_cur;

    // tag FIFO: one entry per accepted read burst, holding owner and beats still to return
    logic [GW-1:0]        r_tag_id  [RSP_FIFO_DEPTH];
    logic [BURST_W-1:0]   r_tag_cnt [RSP_FIFO_DEPTH];
    logic [PW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_count;
    logic                 w_fifo_full, w_fifo_empty;
    logic                 w_push, w_rsp_take, w_pop;

    logic [DATA_W-1:0]    r_readdata;
    logic [NUM_REQ-1:0]   r_readdatavalid;
    logic                 r_rsp_err;

    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_found;
    logic [GW-1:0]        w_pick;

    logic                 w_sel_rd, w_sel_wr;
    logic [BURST_W-1:0]   w_sel_bc_raw, w_sel_bc;
    logic                 w_ddr_read, w_ddr_write;
    logic [NUM_REQ-1:0]   w_waitreq;

    assign w_fifo_full  = (r_count == CW'(RSP_FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);

    // A read can only be taken if its tag has somewhere to go; writes never need a tag.
    assign w_elig = bus.m_write | (bus.m_read & {NUM_REQ{~w_fifo_full}});

    // Round-robin scan starting just after the last master that completed a command.
    always_comb begin : p_arb
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(idx);
            end
        end
    end

    // Command path is muxed from the current grant, independent of state.
    assign w_sel_rd     = bus.m_read[r_grant];
    assign w_sel_wr     = bus.m_write[r_grant];
    assign w_sel_bc_raw = bus.m_burstcount[r_grant*BURST_W +: BURST_W];
    assign w_sel_bc     = (w_sel_bc_raw == '0) ? BURST_W'(1) : w_sel_bc_raw;

    assign bus.DDR4_address    = bus.m_address[r_grant*ADDR_W +: ADDR_W];
    assign bus.DDR4_writedata  = bus.m_writedata[r_grant*DATA_W +: DATA_W];
    assign bus.DDR4_byteenable = bus.m_byteenable[r_grant*BE_W +: BE_W];
    assign bus.DDR4_burstcount = w_sel_bc;
    assign bus.DDR4_read       = w_ddr_read;
    assign bus.DDR4_write      = w_ddr_write;
    assign bus.m_waitrequest   = w_waitreq;
    assign bus.m_readdata      = r_readdata;
    assign bus.m_readdatavalid = r_readdatavalid;
    assign rsp_err             = r_rsp_err;

    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_beat_nxt  = r_beat_cnt;
        w_len_nxt   = r_wr_len;
        w_len_cur   = r_wr_len;
        w_push      = 1'b0;
        w_ddr_read  = 1'b0;
        w_ddr_write = 1'b0;
        w_waitreq   = '1;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_beat_nxt  = '0;
                    // read wins over a simultaneous write from the same master
                    w_state_nxt = (bus.m_read[w_pick] && !w_fifo_full) ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                w_ddr_read         = w_sel_rd;
                w_waitreq[r_grant] = bus.DDR4_waitrequest;
                if (w_sel_rd && !bus.DDR4_waitrequest) begin
                    w_push      = 1'b1;
                    w_last_nxt  = r_grant;
                    w_state_nxt = ST_IDLE;
                end else if (!w_sel_rd) begin
                    // master withdrew: no command issued, priority unchanged
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                w_ddr_write        = w_sel_wr;
                w_waitreq[r_grant] = bus.DDR4_waitrequest;
                if (w_sel_wr && !bus.DDR4_waitrequest) begin
                    // burst length is taken from the first beat; later beats use the latched copy
                    w_len_cur = (r_beat_cnt == '0) ? w_sel_bc : r_wr_len;
                    if (r_beat_cnt + BURST_W'(1) == w_len_cur) begin
                        w_beat_nxt  = '0;
                        w_last_nxt  = r_grant;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_beat_nxt = r_beat_cnt + BURST_W'(1);
                        w_len_nxt  = w_len_cur;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge DDR4_USERCLK) begin
        if (!SoftReset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_wr_len     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_beat_cnt   <= w_beat_nxt;
            r_wr_len     <= w_len_nxt;
        end
    end

    // Returns are consumed only against an outstanding tag; the head entry counts down to its pop.
    assign w_rsp_take = bus.DDR4_readdatavalid && !w_fifo_empty;
    assign w_pop      = w_rsp_take && (r_tag_cnt[r_rptr] == BURST_W'(1));

    // Push never targets the head entry being decremented: push needs not-full, take needs not-empty.
    always_ff @(posedge DDR4_USERCLK) begin
        if (w_push) begin
            r_tag_id[r_wptr]  <= r_grant;
            r_tag_cnt[r_wptr] <= w_sel_bc;
        end
        if (w_rsp_take && !w_pop) begin
            r_tag_cnt[r_rptr] <= r_tag_cnt[r_rptr] - BURST_W'(1);
        end
    end

    always_ff @(posedge DDR4_USERCLK) begin
        if (!SoftReset_n) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_readdata      <= '0;
            r_readdatavalid <= '0;
            r_rsp_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_rsp_take) begin
                r_readdata      <= bus.DDR4_readdata;
                r_readdatavalid <= NUM_REQ'(1) << r_tag_id[r_rptr];
            end else begin
                r_readdatavalid <= '0;
            end
            if (bus.DDR4_readdatavalid && w_fifo_empty) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    a_burstcount_nonzero: assert property (@(posedge DDR4_USERCLK) disable iff (!SoftReset_n)
        (w_ddr_read || w_ddr_write) |-> (w_sel_bc_raw != '0));

endmodule
